// File: rtl/rotate_decoder_pkg.sv
// Shared definitions for the rotate decoder: FSM state type and widths.
package rotate_decoder_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/rotate_decoder_rotate1_right.sv
// Single-step circular right rotate of one data word.
module rotate1_right
    import rotate_decoder_pkg::*;
(
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    // LSB wraps around into the MSB position
    assign dout = {din[0], din[DATA_W-1:1]};

endmodule

// File: rtl/rotate_decoder.sv
// Rotate decoder: finds the smallest right-rotate amount k that turns Orig
// into Rot by rotating a working copy one step per cycle.
// Optional build macro ROTATE_DECODER_SHORTEST_EN reports the shorter
// direction (left rotate for k in 5..7) instead of the raw right amount.
module rotate_decoder
    import rotate_decoder_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              Start,
    input  logic [DATA_W-1:0] Orig,
    input  logic [DATA_W-1:0] Rot,
    output logic              Busy,
    output logic              Done,
    output logic              Found,
    output logic [CNT_W-1:0]  Num,
    output logic              LR
);

    state_t              state;
    logic [DATA_W-1:0]   work;
    logic [DATA_W-1:0]   target;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   work_rot;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    rotate1_right u_rot1 (
        .din  (work),
        .dout (work_rot)
    );

    // Map a matching right-rotate amount to the reported {LR, Num} pair.
    function automatic logic [CNT_W:0] encode(input logic [CNT_W-1:0] k);
`ifdef ROTATE_DECODER_SHORTEST_EN
        // Rotating right by k equals rotating left by 8-k; 0-k in 3 bits is 8-k
        if (k >= CNT_W'(5))
            encode = {1'b1, CNT_W'(0) - k};
        else
            encode = {1'b0, k};
`else
        encode = {1'b0, k};
`endif
    endfunction

    // Search FSM with all outputs registered; one compare/rotate per cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            work   <= '0;
            target <= '0;
            cnt    <= '0;
            Busy   <= 1'b0;
            Done   <= 1'b0;
            Found  <= 1'b0;
            Num    <= '0;
            LR     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        work   <= Orig;
                        target <= Rot;
                        cnt    <= '0;
                        Busy   <= 1'b1;
                        state  <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (work == target) begin
                        Found       <= 1'b1;
                        {LR, Num}   <= encode(cnt);
                        Done        <= 1'b1;
                        state       <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        // All eight rotations tried without a match
                        Found <= 1'b0;
                        Num   <= '0;
                        LR    <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        work <= work_rot;
                        cnt  <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotate_decoder.sv
// Self-checking bench for rotate_decoder: directed corner cases plus random
// transactions checked against an arithmetic rotate model.
module tb_rotate_decoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       Start = 1'b0;
    logic [7:0] Orig = 8'h00;
    logic [7:0] Rot = 8'h00;
    logic       Busy, Done, Found, LR;
    logic [2:0] Num;

    int errors = 0;
    int checks = 0;

    rotate_decoder dut (
        .clk   (clk),
        .rst   (rst),
        .Start (Start),
        .Orig  (Orig),
        .Rot   (Rot),
        .Busy  (Busy),
        .Done  (Done),
        .Found (Found),
        .Num   (Num),
        .LR    (LR)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: circular right rotate computed with plain integer arithmetic
    function automatic int rotr(input int v, input int k);
        return ((v >> k) | (v << (8 - k))) & 255;
    endfunction

    // Reference result: smallest k with rotr(o,k)==r, reported form of Num/LR
    task automatic model(input logic [7:0] o, input logic [7:0] r,
                         output logic f, output int k, output int num, output int lr);
        f = 1'b0; k = 0; num = 0; lr = 0;
        for (int i = 7; i >= 0; i--)
            if (rotr(int'(o), i) == int'(r)) begin f = 1'b1; k = i; end
        if (f) begin
`ifdef ROTATE_DECODER_SHORTEST_EN
            if (k >= 5) begin num = 8 - k; lr = 1; end
            else begin num = k; lr = 0; end
`else
            num = k; lr = 0;
`endif
        end
    endtask

    // One transaction; inj>0 pulses a competing Start during cycle T+inj
    task automatic run(input string tag, input logic [7:0] o, input logic [7:0] r, input int inj);
        logic f; int k, num, lr, lat;
        model(o, r, f, k, num, lr);
        @(negedge clk);
        Start = 1'b1; Orig = o; Rot = r;
        @(posedge clk);
        #1;
        Start = 1'b0; Orig = 8'($urandom); Rot = 8'($urandom);
        lat = 0;
        for (int n = 1; n <= 20 && lat == 0; n++) begin
            @(negedge clk);
            if (n == inj) begin Start = 1'b1; Orig = ~o; Rot = ~o; end
            else Start = 1'b0;
            if (Done) lat = n;
            else check({tag, "_busy"}, Busy, 1);
        end
        Start = 1'b0;
        check({tag, "_latency"}, lat, f ? k + 2 : 9);
        check({tag, "_found"}, Found, f);
        check({tag, "_num"}, Num, num);
        check({tag, "_lr"}, LR, lr);
        check({tag, "_busy_done"}, Busy, 1);
        @(negedge clk);
        check({tag, "_done_pulse"}, Done, 0);
        check({tag, "_busy_idle"}, Busy, 0);
    endtask

    initial begin
        logic [7:0] o, r;
        #3;
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);
        check("reset_found", Found, 0);
        check("reset_num", Num, 0);
        check("reset_lr", LR, 0);
        @(negedge clk);
        rst = 1'b0;

        run("rot1", 8'h81, 8'hC0, 0);
        run("rot7", 8'h01, 8'h02, 0);
        run("nomatch", 8'h03, 8'h05, 0);
        run("per55", 8'h55, 8'hAA, 0);
        run("perFF", 8'hFF, 8'hFF, 0);
        run("zero", 8'h00, 8'h00, 0);
        run("per33", 8'h33, 8'h99, 0);
        run("rot5", 8'h01, 8'h08, 0);
        run("ignore", 8'h01, 8'h02, 3);

        // Reset mid-search at T+4, competing Start at T+3
        @(negedge clk);
        Start = 1'b1; Orig = 8'h01; Rot = 8'h02;
        @(posedge clk);
        #1;
        Start = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            Start = (n == 3);
        end
        Start = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", Busy, 0);
        check("midrst_done", Done, 0);
        check("midrst_found", Found, 0);
        check("midrst_num", Num, 0);
        check("midrst_lr", LR, 0);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("inrst_done", Done, 0);
        end
        rst = 1'b0;
        Start = 1'b1; Orig = 8'hFF; Rot = 8'hFF;
        @(posedge clk);
        #1;
        Start = 1'b0;
        check("postrst_accept", Busy, 1);
        @(negedge clk);
        check("postrst_nodone", Done, 0);
        @(negedge clk);
        check("postrst_done", Done, 1);
        check("postrst_found", Found, 1);
        check("postrst_num", Num, 0);
        @(negedge clk);
        check("postrst_idle", Busy, 0);

        // Random transactions, about half constructed to match
        for (int i = 0; i < 40; i++) begin
            o = 8'($urandom);
            if ($urandom_range(1, 0) == 1) r = 8'(rotr(int'(o), int'($urandom_range(7, 0))));
            else r = 8'($urandom);
            run("rand", o, r, (i % 3 == 0) ? int'($urandom_range(8, 1)) : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
